// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronizes the raw bus, deframes 11-bit frames
// and tracks the held key through make / break (F0) / extended (E0) codes.
module ps2_key_decoder #(
   parameter int SYNC_STAGES = 3,
   parameter int TIMEOUT     = 50000,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic [7:0]       scan_code,
   output logic             key_down,
   output logic [CNT_W-1:0] press_count,
   output logic             code_valid,
   output logic             frame_err
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   fall_edge;
   logic                   bit_in;

   // Preset to 1 so the idle bus is what the edge detector sees out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign fall_edge = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
   assign bit_in    = data_sync_q[SYNC_STAGES-1];

   rx_state_t        rx_state_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic             parity_q;
   logic [TO_W-1:0]  to_cnt_q;
   logic             byte_ready_q;
   logic             frame_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q   <= RX_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         to_cnt_q     <= '0;
         byte_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         byte_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (rx_state_q != RX_IDLE && !fall_edge && to_cnt_q == '0) begin
            rx_state_q  <= RX_IDLE;
            frame_err_q <= 1'b1;
         end else begin
            // Down-counter reloads on every edge; it only runs mid-frame.
            if (fall_edge) begin
               to_cnt_q <= TO_W'(TIMEOUT - 1);
            end else if (rx_state_q != RX_IDLE) begin
               to_cnt_q <= to_cnt_q - TO_W'(1);
            end
            case (rx_state_q)
               RX_IDLE: begin
                  if (fall_edge && !bit_in) begin
                     rx_state_q <= RX_DATA;
                     bit_cnt_q  <= '0;
                  end
               end
               RX_DATA: begin
                  if (fall_edge) begin
                     shift_q   <= {bit_in, shift_q[7:1]};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
                  end
               end
               RX_PARITY: begin
                  if (fall_edge) begin
                     parity_q   <= bit_in;
                     rx_state_q <= RX_STOP;
                  end
               end
               RX_STOP: begin
                  if (fall_edge) begin
                     rx_state_q <= RX_IDLE;
                     if (bit_in && (^{shift_q, parity_q})) byte_ready_q <= 1'b1;
                     else                                  frame_err_q  <= 1'b1;
                  end
               end
               default: rx_state_q <= RX_IDLE;
            endcase
         end
      end
   end

   logic [7:0]       scan_code_q,   scan_code_d;
   logic             key_down_q,    key_down_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;
   logic             break_pend_q,  break_pend_d;
   logic             code_valid_q,  code_valid_d;

   // shift_q holds the finished byte while byte_ready_q is high.
   always_comb begin
      scan_code_d   = scan_code_q;
      key_down_d    = key_down_q;
      press_count_d = press_count_q;
      break_pend_d  = break_pend_q;
      code_valid_d  = 1'b0;
      if (byte_ready_q) begin
         if (shift_q == 8'hE0) begin
            break_pend_d = break_pend_q;
         end else if (shift_q == 8'hF0) begin
            break_pend_d = 1'b1;
         end else if (break_pend_q) begin
            break_pend_d = 1'b0;
            if (shift_q == scan_code_q) key_down_d = 1'b0;
         end else if (!key_down_q || shift_q != scan_code_q) begin
            scan_code_d   = shift_q;
            key_down_d    = 1'b1;
            press_count_d = press_count_q + CNT_W'(1);
            code_valid_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_code_q   <= '0;
         key_down_q    <= 1'b0;
         press_count_q <= '0;
         break_pend_q  <= 1'b0;
         code_valid_q  <= 1'b0;
      end else begin
         scan_code_q   <= scan_code_d;
         key_down_q    <= key_down_d;
         press_count_q <= press_count_d;
         break_pend_q  <= break_pend_d;
         code_valid_q  <= code_valid_d;
      end
   end

   assign scan_code   = scan_code_q;
   assign key_down    = key_down_q;
   assign press_count = press_count_q;
   assign code_valid  = code_valid_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random
// byte streams compared against a behavioural key-state model.
module tb_ps2_key_decoder;

   localparam int SYNC = 3;
   localparam int TMO  = 300;
   localparam int CW   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ps2_clk = 1'b1;
   logic          ps2_data = 1'b1;
   logic [7:0]    scan_code;
   logic          key_down;
   logic [CW-1:0] press_count;
   logic          code_valid;
   logic          frame_err;

   always #5 clk = ~clk;

   ps2_key_decoder #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .scan_code(scan_code), .key_down(key_down), .press_count(press_count),
      .code_valid(code_valid), .frame_err(frame_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int   cyc = 0;
   int   cv_cnt = 0, err_cnt = 0, cv_last = 0, err_last = 0, dbl_cnt = 0;
   logic cv_prev = 1'b0, err_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (code_valid) begin
         cv_cnt++;
         cv_last = cyc;
         if (cv_prev) dbl_cnt++;
      end
      if (frame_err) begin
         err_cnt++;
         err_last = cyc;
         if (err_prev) dbl_cnt++;
      end
      cv_prev  = code_valid;
      err_prev = frame_err;
   end

   // Reference key state
   logic [7:0] m_sc  = 8'h00;
   logic       m_kd  = 1'b0;
   logic       m_brk = 1'b0;
   logic [7:0] m_cnt = 8'h00;
   int         half  = 6;

   task automatic model_reset();
      m_sc = 8'h00; m_kd = 1'b0; m_brk = 1'b0; m_cnt = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] b, output bit pulse);
      pulse = 1'b0;
      if (b == 8'hE0) begin
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (m_brk) begin
         m_brk = 1'b0;
         if (b == m_sc) m_kd = 1'b0;
      end else if (!m_kd || b != m_sc) begin
         m_sc  = b;
         m_kd  = 1'b1;
         m_cnt = m_cnt + 8'd1;
         pulse = 1'b1;
      end
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, ".scan_code"},   32'(scan_code),   32'(m_sc));
      check_eq({tag, ".key_down"},    32'(key_down),    32'(m_kd));
      check_eq({tag, ".press_count"}, 32'(press_count), 32'(m_cnt));
   endtask

   task automatic drive_bits(input logic [10:0] bits, input int nbits, output int fall_cyc);
      fall_cyc = 0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (half) @(negedge clk);
         ps2_clk  = 1'b0;
         fall_cyc = cyc;
         repeat (half) @(negedge clk);
         ps2_clk  = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input string tag, input logic [7:0] b,
                             input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      int          stop_cyc, cv0, err0;
      bit          good, pulse;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      good = !bad_par && !bad_stop;
      cv0  = cv_cnt;
      err0 = err_cnt;
      drive_bits(bits, 11, stop_cyc);
      repeat (8) @(negedge clk);
      pulse = 1'b0;
      if (good) model_byte(b, pulse);
      check_eq({tag, ".cv_pulses"},  32'(cv_cnt - cv0),  32'(pulse));
      check_eq({tag, ".err_pulses"}, 32'(err_cnt - err0), 32'(!good));
      if (pulse) check_eq({tag, ".cv_latency"}, 32'(cv_last - stop_cyc), 32'(SYNC + 1));
      if (!good) check_eq({tag, ".err_latency"}, 32'(err_last - stop_cyc), 32'(SYNC));
      check_state(tag);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          fall_cyc, err0, d;
      logic [7:0]  codes [4];
      logic [7:0]  b;
      bit          bp, bs;
      codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h15; codes[3] = 8'h75;

      repeat (4) @(negedge clk);
      check_state("reset");
      check_eq("reset.code_valid", 32'(code_valid), 32'd0);
      check_eq("reset.frame_err",  32'(frame_err),  32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("reset_release.no_err", 32'(err_cnt), 32'd0);

      send_frame("make_1c", 8'h1C, 0, 0);
      send_frame("rep_1c_a", 8'h1C, 0, 0);
      send_frame("rep_1c_b", 8'h1C, 0, 0);
      send_frame("brk_f0", 8'hF0, 0, 0);
      send_frame("brk_1c", 8'h1C, 0, 0);
      check_eq("brk.count_is_1", 32'(press_count), 32'd1);

      send_frame("bad_parity_15", 8'h15, 1, 0);
      send_frame("bad_stop_15",   8'h15, 0, 1);
      send_frame("good_15",       8'h15, 0, 0);

      // Partial frame then silence: start bit plus four data bits
      err0 = err_cnt;
      drive_bits(11'b000_0101_0010, 5, fall_cyc);
      repeat (TMO + 10) @(negedge clk);
      d = err_last - fall_cyc;
      check_eq("timeout.err_pulses", 32'(err_cnt - err0), 32'd1);
      check_eq("timeout.boundary", 32'(d >= TMO + 1 && d <= TMO + SYNC + 2), 32'd1);
      check_state("timeout");
      send_frame("after_to_32", 8'h32, 0, 0);

      send_frame("ext_e0",   8'hE0, 0, 0);
      send_frame("ext_75",   8'h75, 0, 0);
      send_frame("extb_e0",  8'hE0, 0, 0);
      send_frame("extb_f0",  8'hF0, 0, 0);
      send_frame("extb_75",  8'h75, 0, 0);

      for (int i = 0; i < 80; i++) begin
         half = int'($urandom_range(5, 8));
         case ($urandom_range(0, 9))
            0:       b = 8'hE0;
            1, 2:    b = 8'hF0;
            3, 4, 5, 6: b = codes[$urandom_range(0, 3)];
            default: b = 8'($urandom);
         endcase
         bp = ($urandom_range(0, 11) == 0);
         bs = !bp && ($urandom_range(0, 11) == 0);
         send_frame("rand", b, bp, bs);
      end
      half = 6;

      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      check_state("reset2");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      send_frame("hold_1c", 8'h1C, 0, 0);
      send_frame("hold_32", 8'h32, 0, 0);
      send_frame("hold_f0", 8'hF0, 0, 0);
      send_frame("hold_1c_brk", 8'h1C, 0, 0);
      check_eq("hold.scan_code", 32'(scan_code),   32'h32);
      check_eq("hold.count",     32'(press_count), 32'd2);
      check_eq("hold.key_down",  32'(key_down),    32'd1);

      for (int i = 0; i < 254; i++) begin
         half = int'($urandom_range(5, 7));
         send_frame("wrap", (i % 2 == 0) ? 8'h1C : 8'h32, 0, 0);
      end
      half = 6;
      check_eq("wrap.count_zero", 32'(press_count), 32'd0);

      // Reset in the middle of a frame
      err0 = err_cnt;
      drive_bits(11'b110_0011_0100, 5, fall_cyc);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      check_state("midrst");
      check_eq("midrst.code_valid", 32'(code_valid), 32'd0);
      check_eq("midrst.frame_err",  32'(frame_err),  32'd0);
      rst = 1'b0;
      repeat (TMO + 20) @(negedge clk);
      check_eq("midrst.no_err", 32'(err_cnt - err0), 32'd0);
      send_frame("midrst_1c", 8'h1C, 0, 0);
      send_frame("midrst_f0", 8'hF0, 0, 0);
      send_frame("midrst_1c_brk", 8'h1C, 0, 0);

      check_eq("single_cycle_pulses", 32'(dbl_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
